// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - fixed-priority merge of fetch and data ports onto one single-beat memory bus
// One transaction outstanding; the data port wins whenever both request in IDLE.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int IDATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic               i_addr_ok,
    output logic               i_data_ok,
    output logic [IDATA_W-1:0] i_data,
    input  logic               d_valid,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [2:0]         d_size,
    input  logic [7:0]         d_strobe,
    input  logic [DATA_W-1:0]  d_wdata,
    output logic               d_addr_ok,
    output logic               d_data_ok,
    output logic [DATA_W-1:0]  d_rdata,
    output logic               m_valid,
    output logic               m_is_write,
    output logic [2:0]         m_size,
    output logic [ADDR_W-1:0]  m_addr,
    output logic [7:0]         m_strobe,
    output logic [DATA_W-1:0]  m_wdata,
    input  logic               m_ready,
    input  logic               m_last,
    input  logic [DATA_W-1:0]  m_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_REQ  = 3'd1,
        I_REQ  = 3'd2,
        D_RESP = 3'd3,
        I_RESP = 3'd4
    } state_t;

    state_t state;

    // The m_* outputs double as the request registers, so they stay frozen
    // for the whole transaction regardless of what the ports do meanwhile.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            m_valid    <= 1'b0;
            m_is_write <= 1'b0;
            m_size     <= '0;
            m_addr     <= '0;
            m_strobe   <= '0;
            m_wdata    <= '0;
            i_addr_ok  <= 1'b0;
            i_data_ok  <= 1'b0;
            i_data     <= '0;
            d_addr_ok  <= 1'b0;
            d_data_ok  <= 1'b0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_valid) begin
                        m_valid    <= 1'b1;
                        m_addr     <= d_addr;
                        m_size     <= d_size;
                        m_strobe   <= d_strobe;
                        m_wdata    <= d_wdata;
                        m_is_write <= |d_strobe;
                        state      <= D_REQ;
                    end else if (i_valid) begin
                        m_valid    <= 1'b1;
                        m_addr     <= i_addr;
                        m_size     <= 3'd2;
                        m_strobe   <= '0;
                        m_wdata    <= '0;
                        m_is_write <= 1'b0;
                        state      <= I_REQ;
                    end
                end
                // Beats without m_last are dropped; this bus never issues bursts.
                D_REQ: begin
                    if (m_ready && m_last) begin
                        m_valid   <= 1'b0;
                        d_rdata   <= m_rdata;
                        d_addr_ok <= 1'b1;
                        d_data_ok <= 1'b1;
                        state     <= D_RESP;
                    end
                end
                I_REQ: begin
                    if (m_ready && m_last) begin
                        m_valid   <= 1'b0;
                        i_data    <= m_addr[2] ? m_rdata[2*IDATA_W-1:IDATA_W]
                                               : m_rdata[IDATA_W-1:0];
                        i_addr_ok <= 1'b1;
                        i_data_ok <= 1'b1;
                        state     <= I_RESP;
                    end
                end
                // Response cycle keeps a still-high valid from being re-issued.
                D_RESP: begin
                    d_addr_ok <= 1'b0;
                    d_data_ok <= 1'b0;
                    state     <= IDLE;
                end
                I_RESP: begin
                    i_addr_ok <= 1'b0;
                    i_data_ok <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic [63:0] i_addr = '0;
    logic        i_addr_ok, i_data_ok;
    logic [31:0] i_data;
    logic        d_valid = 1'b0;
    logic [63:0] d_addr = '0;
    logic [2:0]  d_size = '0;
    logic [7:0]  d_strobe = '0;
    logic [63:0] d_wdata = '0;
    logic        d_addr_ok, d_data_ok;
    logic [63:0] d_rdata;
    logic        m_valid, m_is_write;
    logic [2:0]  m_size;
    logic [63:0] m_addr, m_wdata;
    logic [7:0]  m_strobe;
    logic        m_ready = 1'b0;
    logic        m_last = 1'b0;
    logic [63:0] m_rdata = '0;

    mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .IDATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok), .i_data(i_data),
        .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_is_write(m_is_write), .m_size(m_size), .m_addr(m_addr),
        .m_strobe(m_strobe), .m_wdata(m_wdata), .m_ready(m_ready), .m_last(m_last),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } txn_t;

    typedef struct {
        bit          do_d;
        bit          do_i;
        logic [63:0] da;
        logic [2:0]  ds;
        logic [7:0]  dst;
        logic [63:0] dw;
        logic [63:0] ia;
        int          wt;
        int          jk;
        int          hold;
        bit          use_rd;
        logic [63:0] rd;
    } vec_t;

    txn_t        exp_q[$];
    txn_t        mon_e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cfg_wait = 0;
    int          cfg_junk = 0;
    bit          cfg_use = 0;
    logic [63:0] cfg_rdata = '0;
    bit          mon_en = 0;
    int          wcnt = 0;
    int          jcnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return {a[31:0] ^ 32'h1357_9bdf, ~a[63:32]};
    endfunction

    // Memory model: cfg_wait idle cycles, cfg_junk non-last beats, then the last beat.
    initial forever begin
        @(posedge clk); #1;
        if (!rst || !m_valid) begin
            m_ready = 1'b0; m_last = 1'b0; wcnt = cfg_wait; jcnt = cfg_junk;
        end else if (wcnt > 0) begin
            m_ready = 1'b0; m_last = 1'b0; wcnt--;
        end else if (jcnt > 0) begin
            m_ready = 1'b1; m_last = 1'b0; m_rdata = ~mem_word(m_addr); jcnt--;
        end else begin
            m_ready = 1'b1; m_last = 1'b1;
            m_rdata = cfg_use ? cfg_rdata : mem_word(m_addr);
        end
    end

    always @(negedge clk) begin
        if (mon_en && rst) begin
            check("addr_ok_eq_data_ok_d", 64'(d_addr_ok), 64'(d_data_ok));
            check("addr_ok_eq_data_ok_i", 64'(i_addr_ok), 64'(i_data_ok));
            if (m_valid) begin
                check("issue_has_txn", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    check("m_addr", m_addr, exp_q[0].addr);
                    check("m_size", 64'(m_size), 64'(exp_q[0].size));
                    check("m_strobe", 64'(m_strobe), 64'(exp_q[0].strobe));
                    check("m_is_write", 64'(m_is_write), 64'(|exp_q[0].strobe));
                    if (exp_q[0].is_d) check("m_wdata", m_wdata, exp_q[0].wdata);
                end
            end
            if (d_data_ok || i_data_ok) begin
                check("ok_has_txn", 64'(exp_q.size() > 0), 64'd1);
                check("ok_exclusive", 64'(d_data_ok & i_data_ok), 64'd0);
                check("ok_m_valid_low", 64'(m_valid), 64'd0);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("ok_port_is_d", 64'(d_data_ok), 64'(mon_e.is_d));
                    if (mon_e.is_d)
                        check("d_rdata", d_rdata, mon_e.rdata);
                    else
                        check("i_data", 64'(i_data),
                              64'(mon_e.addr[2] ? mon_e.rdata[63:32] : mon_e.rdata[31:0]));
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        txn_t t;
        int   cyc = 0;
        int   first = -1;
        int   dh = -1;
        bit   d_on, i_on;
        cfg_wait = v.wt; cfg_junk = v.jk; cfg_use = v.use_rd; cfg_rdata = v.rd;
        if (v.do_d) begin
            t = '{1'b1, v.da, v.ds, v.dst, v.dw, v.use_rd ? v.rd : mem_word(v.da)};
            exp_q.push_back(t);
            if (v.hold > 0) exp_q.push_back(t);
        end
        if (v.do_i) begin
            t = '{1'b0, v.ia, 3'd2, 8'd0, 64'd0, v.use_rd ? v.rd : mem_word(v.ia)};
            exp_q.push_back(t);
        end
        @(posedge clk); #1;
        d_valid = v.do_d; d_addr = v.da; d_size = v.ds; d_strobe = v.dst; d_wdata = v.dw;
        i_valid = v.do_i; i_addr = v.ia;
        d_on = v.do_d; i_on = v.do_i;
        while ((exp_q.size() > 0 || d_on || i_on) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (first < 0 && (d_data_ok || i_data_ok)) first = cyc;
            if (d_on) begin
                if (dh == 0) begin d_valid = 1'b0; d_on = 0; end
                else if (dh > 0) dh--;
                else if (d_data_ok) dh = v.hold;
            end
            if (i_on && i_data_ok) i_on = 0;
            else if (!i_on) i_valid = 1'b0;
        end
        i_valid = 1'b0;
        check("scn_all_done", 64'(exp_q.size()), 64'd0);
        check("first_latency", 64'(first), 64'(v.wt + v.jk + 2));
        if (exp_q.size() != 0) begin
            exp_q.delete();
            d_valid = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic reset_mid(input bit at_ok);
        cfg_wait = at_ok ? 0 : 20; cfg_junk = 0; cfg_use = 0;
        exp_q.push_back('{1'b1, 64'h500, 3'd3, 8'd0, 64'd0, mem_word(64'h500)});
        @(posedge clk); #1;
        d_valid = 1'b1; d_addr = 64'h500; d_size = 3'd3; d_strobe = 8'd0; d_wdata = '0;
        repeat (at_ok ? 2 : 3) @(posedge clk);
        #1;
        check("pre_rst_busy", 64'(at_ok ? d_data_ok : m_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_ok_pulses", 64'({d_addr_ok, d_data_ok, i_addr_ok, i_data_ok}), 64'd0);
        exp_q.delete();
        d_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_idle", 64'(m_valid), 64'd0);
        end
    endtask

    vec_t vecs[7];
    vec_t rv;

    initial begin
        vecs[0] = '{0, 1, 64'h0, 3'd0, 8'h00, 64'h0, 64'h8000_0004, 1, 0, 0, 1, 64'h1111_2222_3333_4444};
        vecs[1] = '{1, 1, 64'h100, 3'd2, 8'h0F, 64'h0000_0000_cafe_f00d, 64'h8000_0000, 0, 0, 0, 0, 64'h0};
        vecs[2] = '{1, 0, 64'h40, 3'd3, 8'h00, 64'h0, 64'h0, 5, 0, 0, 0, 64'h0};
        vecs[3] = '{1, 0, 64'h300, 3'd3, 8'hFF, 64'h0123_4567_89ab_cdef, 64'h0, 0, 0, 2, 0, 64'h0};
        vecs[4] = '{1, 0, 64'h200, 3'd3, 8'h00, 64'h0, 64'h0, 0, 0, 0, 1, 64'hDEAD_BEEF_0000_0001};
        vecs[5] = '{1, 0, 64'h7f8, 3'd1, 8'hC0, 64'hAAAA_0000_0000_0000, 64'h0, 2, 3, 0, 0, 64'h0};
        vecs[6] = '{0, 1, 64'h0, 3'd0, 8'h00, 64'h0, 64'h8000_0000, 0, 0, 0, 0, 64'h0};

        #2;
        check("reset_m_valid", 64'(m_valid), 64'd0);
        check("reset_ok", 64'({d_addr_ok, d_data_ok, i_addr_ok, i_data_ok}), 64'd0);
        check("reset_m_addr", m_addr, 64'd0);
        check("reset_rdata", d_rdata, 64'd0);
        check("reset_i_data", 64'(i_data), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1;

        for (int k = 0; k < 7; k++) run_vec(vecs[k]);

        for (int k = 0; k < 40; k++) begin
            rv.do_d   = ($urandom % 2) == 1;
            rv.do_i   = rv.do_d ? (($urandom % 2) == 1) : 1'b1;
            rv.da     = {$urandom(), $urandom()};
            rv.ds     = 3'($urandom_range(0, 3));
            rv.dst    = (($urandom % 3) == 0) ? 8'h00 : 8'($urandom);
            rv.dw     = {$urandom(), $urandom()};
            rv.ia     = {$urandom(), $urandom()} & ~64'h3;
            rv.wt     = $urandom_range(0, 4);
            rv.jk     = $urandom_range(0, 2);
            rv.hold   = (rv.do_d && !rv.do_i && (($urandom % 4) == 0)) ? $urandom_range(1, 2) : 0;
            rv.use_rd = 0;
            rv.rd     = '0;
            run_vec(rv);
        end

        reset_mid(1'b0);
        reset_mid(1'b1);
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
